dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core. It answers the MEM-stage load/store requests with a valid/ready handshake and a fixed, parameterised access latency. It replaces the single-cycle data memory so the core can be tested against realistic multi-cycle memory. It also exports a stall indication for the hazard-detection logic, which holds PC, IF/ID and upstream registers while an access is outstanding.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with a fixed LATENCY and a pipeline stall output.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag addresses with addr[1:0] != 0 as errors.
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          acc;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [IW-1:0] acc_idx;
  logic          mem_wr;

  // Next-state, access selection and combinational handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc       = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle latency performs the access at the acceptance edge
            state_d   = S_RESP;
            acc       = 1'b1;
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // cnt reaches zero on the edge that performs the access
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          acc     = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    acc_err = (acc_addr >= ADDR_LIMIT) || (acc_addr[1:0] != 2'b00);
`else
    acc_err = (acc_addr >= ADDR_LIMIT);
`endif
    acc_idx  = acc_addr[2 +: IW];
    mem_wr   = acc && acc_we && !acc_err;
    rvalid_d = acc;
    rdata_d  = (acc && !acc_we && !acc_err) ? mem_q[acc_idx] : 32'h0;
    err_d    = acc && acc_err;

    ready_o  = (state_q != S_BUSY);
    stall_o  = (state_q == S_BUSY) || req_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage array, cleared on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_wr) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance and a LATENCY=1 instance on one clock/reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err, stall;
  logic [31:0] rdata;
  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        ready1, rvalid1, err1, stall1;
  logic [31:0] rdata1;

  int passed = 0;
  int total  = 0;

  logic        v_we   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_addr [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8};
  logic [31:0] v_data [5] = '{32'h11, 32'h22, 32'h0, 32'h0, 32'h0};
  logic [31:0] v_exp  [5] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h0};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .LATENCY(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .stall_o(stall)
  );

  dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .ready_o(ready1), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request to the LATENCY=4 instance and drop it after the acceptance edge
  task automatic issue(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    chk({tag, "_ready"}, 32'(ready), 32'h1);
    chk({tag, "_stall_req"}, 32'(stall), 32'h1);
    step();
    req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'hBAD0_BAD0;
  endtask

  // Wait (bounded) for the response; expects 3 edges after acceptance with stall held meanwhile
  task automatic await(input string tag, input logic [31:0] erd, input logic eerr);
    int   n  = 0;
    logic ok = 1'b1;
    while (!rvalid && n < 12) begin
      if (!stall || ready) ok = 1'b0;
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, rdata, erd);
    chk({tag, "_err"}, 32'(err), 32'(eerr));
    chk({tag, "_busy_stall"}, 32'(ok), 32'h1);
  endtask

  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr);
    issue(tag, w, a, d);
    await(tag, erd, eerr);
    chk({tag, "_resp_stall"}, 32'(stall), 32'h0);
    step();
    chk({tag, "_pulse"}, 32'(rvalid), 32'h0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ready1", 32'(ready1), 32'h1);
    step();

    access("st8", 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("ld8", 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back: load presented during the store's response cycle
    issue("b2b_st", 1'b1, 32'h10, 32'hCAFE_F00D);
    await("b2b_st", 32'h0, 1'b0);
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
    #1;
    chk("b2b_resp_stall", 32'(stall), 32'h1);
    chk("b2b_resp_ready", 32'(ready), 32'h1);
    step();
    req = 1'b0;
    await("b2b_ld", 32'hCAFE_F00D, 1'b0);
    step();

    access("st_oor", 1'b1, 32'h80, 32'h1234_5678, 32'h0, 1'b1);
    access("ld0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    access("ld_oor", 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);

`ifdef DMEM_MISALIGN_CHECK_EN
    access("st_mis", 1'b1, 32'h6, 32'hA5A5_A5A5, 32'h0, 1'b1);
    access("ld4", 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
`else
    access("st_mis", 1'b1, 32'h6, 32'hA5A5_A5A5, 32'h0, 1'b0);
    access("ld4", 1'b0, 32'h4, 32'h0, 32'hA5A5_A5A5, 1'b0);
`endif

    // Reset in the second BUSY cycle aborts the store
    issue("st_abort", 1'b1, 32'h0, 32'h1);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'h1);
    chk("abort_rvalid", 32'(rvalid), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_err", 32'(err), 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (rvalid) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 32'h0);
    access("ld0_after_abort", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    access("ld8_after_rst", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    // LATENCY=1: continuous requests, each answered on the cycle after its acceptance
    for (int i = 0; i < 5; i++) begin
      req1 = 1'b1; we1 = v_we[i]; addr1 = v_addr[i]; wdata1 = v_data[i];
      #1;
      chk($sformatf("l1_ready_%0d", i), 32'(ready1), 32'h1);
      chk($sformatf("l1_stall_%0d", i), 32'(stall1), 32'h1);
      step();
      chk($sformatf("l1_rvalid_%0d", i), 32'(rvalid1), 32'h1);
      chk($sformatf("l1_rdata_%0d", i), rdata1, v_exp[i]);
      chk($sformatf("l1_err_%0d", i), 32'(err1), 32'h0);
    end
    req1 = 1'b0;
    #1;
    chk("l1_idle_stall", 32'(stall1), 32'h0);
    step();
    chk("l1_end_rvalid", 32'(rvalid1), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
